// File: rtl/kgp_risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_risc_pkg
// Description : Shared definitions for the fetch sequencer: datapath widths,
//               default halt opcode and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_risc_pkg;

    localparam int c_XLEN  = 32;   // address width
    localparam int c_ILEN  = 32;   // instruction width
    localparam int c_OPC_W = 6;    // opcode field width, instruction[31:26]
    localparam int c_OPC_LSB = c_ILEN - c_OPC_W;

    localparam logic [c_OPC_W-1:0] c_HALT_OPCODE = 6'b111111;

    // Sequencer state encoding (binary)
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_REQ    = 3'd1;
    localparam state_t c_ST_WAIT   = 3'd2;
    localparam state_t c_ST_ISSUE  = 3'd3;
    localparam state_t c_ST_HALTED = 3'd4;
    localparam state_t c_ST_PAUSE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Bundles the instruction-memory read port and the core-facing
//               instruction/redirect signals of the fetch sequencer.
//               master : the sequencer (drives imem_en/imem_addr/instruction/
//                        instr_valid, receives imem_rdata and redirects)
//               slave  : memory + core side
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if
    import kgp_risc_pkg::*;
();
    logic              imem_en;
    logic [c_XLEN-1:0] imem_addr;
    logic [c_ILEN-1:0] imem_rdata;
    logic              redirect_valid;
    logic [c_XLEN-1:0] redirect_pc;
    logic [c_ILEN-1:0] instruction;
    logic              instr_valid;

    modport master (
        output imem_en, imem_addr, instruction, instr_valid,
        input  imem_rdata, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, instruction, instr_valid,
        output imem_rdata, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection. A redirect wins and is
//               forced word aligned; otherwise PC advances by 4 and wraps to
//               RESET_PC once the increment passes MAX_PC.
// Ports       : pc             in  current fetch address
//               redirect_valid in  branch-taken indication
//               redirect_pc    in  branch target (low two bits dropped)
//               next_pc        out address of the following fetch
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import kgp_risc_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [c_XLEN-1:0] MAX_PC   = 32'h0000_03FC
)(
    input  logic [c_XLEN-1:0] pc,
    input  logic              redirect_valid,
    input  logic [c_XLEN-1:0] redirect_pc,
    output logic [c_XLEN-1:0] next_pc
);

    // One extra bit so an increment at the top of the address space cannot
    // alias back below MAX_PC.
    logic [c_XLEN:0] w_seq_sum;
    logic            w_unused_align;

    assign w_seq_sum      = {1'b0, pc} + {{c_XLEN{1'b0}}, 1'b0} + (c_XLEN+1)'(4);
    assign w_unused_align = ^redirect_pc[1:0];

    always_comb begin
        next_pc = w_seq_sum[c_XLEN-1:0];
        if (redirect_valid) begin
            next_pc = {redirect_pc[c_XLEN-1:2], 2'b00};
        end else if (w_seq_sum > {1'b0, MAX_PC}) begin
            next_pc = RESET_PC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Each instruction takes three
//               cycles: REQ (read strobe), WAIT (capture read data) and
//               ISSUE (present instruction for one cycle, update PC).
//               Stops on a halt request or on the halt opcode.
// Config      : SINGLE_STEP_EN - adds step_mode/step inputs and a PAUSE
//               state entered after each ISSUE while step_mode is high.
// Ports       : clk, rst        clock, synchronous active-high reset
//               start           pulse, begin fetching at RESET_PC
//               halt_req        stop after the in-flight instruction issues
//               step_mode, step (SINGLE_STEP_EN only) single-step control
//               bus             fetch_sequencer_if.master: imem + core side
//               pc              address of current/next instruction
//               busy, halted    status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import kgp_risc_pkg::*;
#(
    parameter logic [c_XLEN-1:0]  RESET_PC    = 32'h0000_0000,
    parameter logic [c_XLEN-1:0]  MAX_PC      = 32'h0000_03FC,
    parameter logic [c_OPC_W-1:0] HALT_OPCODE = c_HALT_OPCODE
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
`ifdef SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    fetch_sequencer_if.master bus,
    output logic [c_XLEN-1:0] pc,
    output logic              busy,
    output logic              halted
);

    state_t            r_state;
    state_t            w_state_next;
    logic [c_XLEN-1:0] r_pc;
    logic [c_ILEN-1:0] r_instr;
    logic              r_pending_halt;
    logic [c_XLEN-1:0] w_next_pc;
    logic              w_halt_cond;
    logic              w_start_fetch;
    logic              w_in_flight;

    pc_next #(
        .RESET_PC (RESET_PC),
        .MAX_PC   (MAX_PC)
    ) u_pc_next (
        .pc             (r_pc),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .next_pc        (w_next_pc)
    );

    // A halt request arriving in the ISSUE cycle itself still stops after
    // this instruction, so the live request is folded in with the sticky flag.
    assign w_halt_cond   = r_pending_halt || halt_req ||
                           (r_instr[c_ILEN-1:c_OPC_LSB] == HALT_OPCODE);
    assign w_start_fetch = ((r_state == c_ST_IDLE) && start && !halt_req) ||
                           ((r_state == c_ST_HALTED) && start);
    assign w_in_flight   = (r_state == c_ST_REQ) || (r_state == c_ST_WAIT) ||
                           (r_state == c_ST_ISSUE);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !halt_req) w_state_next = c_ST_REQ;
            end
            c_ST_REQ:   w_state_next = c_ST_WAIT;
            c_ST_WAIT:  w_state_next = c_ST_ISSUE;
            c_ST_ISSUE: begin
                if (w_halt_cond) begin
                    w_state_next = c_ST_HALTED;
`ifdef SINGLE_STEP_EN
                end else if (step_mode) begin
                    w_state_next = c_ST_PAUSE;
`endif
                end else begin
                    w_state_next = c_ST_REQ;
                end
            end
            c_ST_HALTED: begin
                if (start) w_state_next = c_ST_REQ;
            end
`ifdef SINGLE_STEP_EN
            c_ST_PAUSE: begin
                if (halt_req)  w_state_next = c_ST_HALTED;
                else if (step) w_state_next = c_ST_REQ;
            end
`endif
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_PC;
            r_instr        <= '0;
            r_pending_halt <= 1'b0;
        end else begin
            if (w_start_fetch) begin
                r_pc           <= RESET_PC;
                r_pending_halt <= 1'b0;
            end else begin
                if (r_state == c_ST_ISSUE) r_pc <= w_next_pc;
                if (w_in_flight && halt_req) r_pending_halt <= 1'b1;
            end
            if (r_state == c_ST_WAIT) r_instr <= bus.imem_rdata;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.imem_en     = 1'b0;
        bus.imem_addr   = '0;
        bus.instr_valid = 1'b0;
        busy            = 1'b0;
        halted          = 1'b0;
        case (r_state)
            c_ST_REQ: begin
                bus.imem_en   = 1'b1;
                bus.imem_addr = r_pc;
                busy          = 1'b1;
            end
            c_ST_WAIT:  busy = 1'b1;
            c_ST_ISSUE: begin
                bus.instr_valid = 1'b1;
                busy            = 1'b1;
            end
            c_ST_HALTED: halted = 1'b1;
`ifdef SINGLE_STEP_EN
            c_ST_PAUSE:  busy = 1'b1;
`endif
            default: ;
        endcase
    end

    assign bus.instruction = r_instr;
    assign pc              = r_pc;

endmodule
`default_nettype wire
